// File: rtl/round_robin_scheduler_if.sv
// Bus between the CPU core and the round-robin scheduler.
// The CPU side (master) reports retirement, I/O, termination and process
// creation; the scheduler side (slave) answers with PC reload requests.
interface round_robin_scheduler_if;

  logic        instr_valid;
  logic [31:0] cur_pc;
  logic        io_req;
  logic        proc_end;
  logic        proc_create;
  logic [3:0]  create_id;
  logic [31:0] create_pc;
  logic        load_pc;
  logic [31:0] next_pc;
  logic [3:0]  cur_proc;
  logic        busy;

  modport master (
    output instr_valid, cur_pc, io_req, proc_end,
    output proc_create, create_id, create_pc,
    input  load_pc, next_pc, cur_proc, busy
  );

  modport slave (
    input  instr_valid, cur_pc, io_req, proc_end,
    input  proc_create, create_id, create_pc,
    output load_pc, next_pc, cur_proc, busy
  );

endinterface

// File: rtl/round_robin_scheduler.sv
// Round-robin time-slice scheduler for up to NPROC user processes.
// Slot 0 stands for the OS; user slots are 1..NPROC. A running process is
// preempted after QUANTUM retired instructions or when it terminates, its PC
// is parked in the process table, and the next active slot is resumed.
// Optional feature: define SCHED_IO_YIELD_EN to make IN/OUT (io_req) yield
// the CPU as well.
module round_robin_scheduler #(
  parameter int NPROC   = 10,
  parameter int QUANTUM = 8
) (
  input logic                    clock,
  input logic                    reset,
  round_robin_scheduler_if.slave bus
);

  localparam logic [3:0] NprocW   = 4'(NPROC);
  localparam logic [7:0] QuantumW = 8'(QUANTUM);

`ifdef SCHED_IO_YIELD_EN
  localparam bit IoYieldEn = 1'b1;
`else
  localparam bit IoYieldEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SAVE,
    SELECT
  } StateT;

  StateT       r_state;
  StateT       w_stateNext;

  logic        r_active  [1:NPROC];
  logic [31:0] r_savedPc [1:NPROC];

  logic [3:0]  r_curProc;
  logic [3:0]  w_curProcNext;
  logic [31:0] r_nextPc;
  logic [31:0] w_nextPcNext;
  logic        r_loadPc;
  logic        w_loadPcNext;
  logic [7:0]  r_quantum;
  logic [7:0]  w_quantumNext;

  logic        w_found;
  logic [3:0]  w_winner;
  logic [3:0]  w_cand;
  logic [4:0]  w_sum;

  logic        w_expiry;
  logic        w_ioYield;
  logic        w_clearEn;
  logic        w_storeEn;
  logic        w_createOk;

  // Find the first active slot strictly after r_curProc, wrapping NPROC back
  // to 1. The scan runs from the farthest slot to the nearest so the nearest
  // hit overwrites the others; the current slot is the farthest (offset
  // NPROC) and so only wins when nothing else is active. In IDLE r_curProc
  // is always 0, so w_found then doubles as "some slot is active".
  always_comb begin
    w_found  = 1'b0;
    w_winner = 4'd0;
    w_sum    = 5'd0;
    w_cand   = 4'd0;
    for (int off = NPROC; off >= 1; off--) begin
      w_sum = {1'b0, r_curProc} + 5'(off);
      if (w_sum > {1'b0, NprocW}) begin
        w_sum = w_sum - {1'b0, NprocW};
      end
      w_cand = w_sum[3:0];
      if (r_active[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // Decode the events of the running process. Termination beats expiry and
  // I/O yield, so a dying process never gets its PC stored. Creation is
  // refused for slot 0, out-of-range slots and the slot that is running.
  always_comb begin
    w_expiry   = (r_state == RUN) && bus.instr_valid &&
                 ((r_quantum + 8'd1) == QuantumW);
    w_ioYield  = IoYieldEn && (r_state == RUN) && bus.io_req;
    w_clearEn  = (r_state == RUN) && bus.proc_end;
    w_storeEn  = !w_clearEn && (w_expiry || w_ioYield);
    w_createOk = bus.proc_create && (bus.create_id != 4'd0) &&
                 (bus.create_id <= NprocW) &&
                 !((r_state == RUN) && (bus.create_id == r_curProc));
  end

  // Next-state and next-output logic. SAVE is a fixed one-cycle stop so the
  // table write of the switch edge has landed before SELECT looks at it.
  always_comb begin
    w_stateNext   = r_state;
    w_curProcNext = r_curProc;
    w_nextPcNext  = r_nextPc;
    w_loadPcNext  = 1'b0;
    w_quantumNext = r_quantum;
    unique case (r_state)
      IDLE: begin
        w_curProcNext = 4'd0;
        if (w_found) begin
          w_stateNext = SAVE;
        end
      end
      RUN: begin
        if (bus.instr_valid) begin
          w_quantumNext = w_expiry ? 8'd0 : (r_quantum + 8'd1);
        end
        if (w_clearEn || w_storeEn) begin
          w_stateNext = SAVE;
        end
      end
      SAVE: begin
        w_stateNext = SELECT;
      end
      SELECT: begin
        w_quantumNext = 8'd0;
        if (w_found) begin
          w_stateNext   = RUN;
          w_curProcNext = w_winner;
          w_nextPcNext  = r_savedPc[w_winner];
          w_loadPcNext  = 1'b1;
        end else begin
          w_stateNext   = IDLE;
          w_curProcNext = 4'd0;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any switch in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_curProc <= 4'd0;
      r_nextPc  <= 32'd0;
      r_loadPc  <= 1'b0;
      r_quantum <= 8'd0;
    end else begin
      r_state   <= w_stateNext;
      r_curProc <= w_curProcNext;
      r_nextPc  <= w_nextPcNext;
      r_loadPc  <= w_loadPcNext;
      r_quantum <= w_quantumNext;
    end
  end

  // Process table updates. Creation never targets the running slot while in
  // RUN, so it cannot collide with the clear/store of that slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_active  <= '{default: 1'b0};
      r_savedPc <= '{default: 32'd0};
    end else begin
      if (w_clearEn) begin
        r_active[r_curProc] <= 1'b0;
      end
      if (w_storeEn) begin
        r_savedPc[r_curProc] <= bus.cur_pc;
      end
      if (w_createOk) begin
        r_active[bus.create_id]  <= 1'b1;
        r_savedPc[bus.create_id] <= bus.create_pc;
      end
    end
  end

  assign bus.load_pc  = r_loadPc;
  assign bus.next_pc  = r_nextPc;
  assign bus.cur_proc = r_curProc;
  assign bus.busy     = (r_state == SAVE) || (r_state == SELECT);

endmodule

// File: tb/tb_round_robin_scheduler.sv
// Bench for round_robin_scheduler: directed stimulus, a cycle-level model
// of the scheduling rules, and literal expectations at key points.
// Honours SCHED_IO_YIELD_EN the same way the design does.
module tb_round_robin_scheduler;

  localparam int NPROC   = 10;
  localparam int QUANTUM = 8;

`ifdef SCHED_IO_YIELD_EN
  localparam bit          IoYield     = 1'b1;
  localparam logic [31:0] Slot1Resume = 32'd310;
`else
  localparam bit          IoYield     = 1'b0;
  localparam logic [31:0] Slot1Resume = 32'd320;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  round_robin_scheduler_if bus ();

  round_robin_scheduler #(
    .NPROC   (NPROC),
    .QUANTUM (QUANTUM)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Model state: table, running slot, slice count, edges left until the
  // next slot is picked (0 = no switch in progress).
  bit          mActive [0:15];
  logic [31:0] mPc     [0:15];
  int          mCur     = 0;
  int          mCount   = 0;
  int          mWait    = 0;
  bit          mRunning = 1'b0;
  bit          mLoad    = 1'b0;
  logic [31:0] mNext    = 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int pickNext(input int from);
    for (int k = 1; k <= NPROC; k++) begin
      int s;
      s = ((from + k - 1) % NPROC) + 1;
      if (mActive[s]) return s;
    end
    return 0;
  endfunction

  task automatic modelStep();
    bit createOk;
    bit expire;
    int id;
    id       = int'(bus.create_id);
    createOk = bus.proc_create && (id != 0) && (id <= NPROC) &&
               !(mRunning && (id == mCur));
    mLoad    = 1'b0;
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        mActive[i] = 1'b0;
        mPc[i]     = 32'd0;
      end
      mCur     = 0;
      mCount   = 0;
      mWait    = 0;
      mRunning = 1'b0;
      mNext    = 32'd0;
      return;
    end
    if (mWait > 0) begin
      mWait--;
      if (mWait == 0) begin
        int s;
        s      = pickNext(mCur);
        mCount = 0;
        if (s != 0) begin
          mCur     = s;
          mNext    = mPc[s];
          mLoad    = 1'b1;
          mRunning = 1'b1;
        end else begin
          mCur     = 0;
          mRunning = 1'b0;
        end
      end
    end else if (mRunning) begin
      expire = 1'b0;
      if (bus.instr_valid) begin
        mCount++;
        if (mCount == QUANTUM) begin
          expire = 1'b1;
          mCount = 0;
        end
      end
      if (bus.proc_end) begin
        mActive[mCur] = 1'b0;
        mWait         = 2;
        mRunning      = 1'b0;
      end else if (expire || (IoYield && bus.io_req)) begin
        mPc[mCur] = bus.cur_pc;
        mWait     = 2;
        mRunning  = 1'b0;
      end
    end else if (pickNext(0) != 0) begin
      mWait = 2;
    end
    if (createOk) begin
      mActive[id] = 1'b1;
      mPc[id]     = bus.create_pc;
    end
  endtask

  // Compare process: advance the model on each edge, check just after it.
  always @(posedge clock) begin
    modelStep();
    #1;
    checkOutput("cur_proc", 32'(bus.cur_proc), 32'(mCur));
    checkOutput("busy", 32'(bus.busy), 32'(mWait > 0));
    checkOutput("load_pc", 32'(bus.load_pc), 32'(mLoad));
    if (mLoad) checkOutput("next_pc", bus.next_pc, mNext);
  end

  task automatic applyStimulus(input bit rst, input bit valid, input logic [31:0] pc,
                               input bit io, input bit endp, input bit create,
                               input logic [3:0] id, input logic [31:0] cpc);
    reset           = rst;
    bus.instr_valid = valid;
    bus.cur_pc      = pc;
    bus.io_req      = io;
    bus.proc_end    = endp;
    bus.proc_create = create;
    bus.create_id   = id;
    bus.create_pc   = cpc;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic retire(input int n, input logic [31:0] pc);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, pc, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic create(input logic [3:0] id, input logic [31:0] pc);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, id, pc);
  endtask

  task automatic expectLoad(input string tag, input logic [31:0] pc, input logic [3:0] proc);
    checkOutput({tag, " load_pc"}, 32'(bus.load_pc), 32'd1);
    checkOutput({tag, " next_pc"}, bus.next_pc, pc);
    checkOutput({tag, " cur_proc"}, 32'(bus.cur_proc), 32'(proc));
  endtask

  task automatic expectIdle(input string tag);
    checkOutput({tag, " load_pc"}, 32'(bus.load_pc), 32'd0);
    checkOutput({tag, " cur_proc"}, 32'(bus.cur_proc), 32'd0);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout, want end of sequence");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    expectIdle("reset");
    checkOutput("reset next_pc", bus.next_pc, 32'd0);

    // Boot: two creates from IDLE, slot 1 loads three edges after the first.
    create(4'd1, 32'd300);
    create(4'd2, 32'd600);
    checkOutput("boot busy", 32'(bus.busy), 32'd1);
    idle(2);
    expectLoad("boot", 32'd300, 4'd1);

    // Quantum expiry hands over to slot 2, then back to slot 1.
    retire(8, 32'd305);
    idle(2);
    expectLoad("expire1", 32'd600, 4'd2);
    retire(8, 32'd650);
    idle(2);
    expectLoad("expire2", 32'd305, 4'd1);

    // io_req on the third instruction.
    retire(2, 32'd307);
    applyStimulus(1'b0, 1'b1, 32'd310, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
`ifdef SCHED_IO_YIELD_EN
    idle(2);
    expectLoad("io yield", 32'd650, 4'd2);
`else
    idle(2);
    checkOutput("io ignored busy", 32'(bus.busy), 32'd0);
    checkOutput("io ignored cur_proc", 32'(bus.cur_proc), 32'd1);
    retire(5, 32'd320);
    idle(2);
    expectLoad("io expire", 32'd650, 4'd2);
`endif

    // proc_end together with expiry on slot 2: slot 2 is gone for good.
    retire(7, 32'd660);
    applyStimulus(1'b0, 1'b1, 32'd670, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
    idle(2);
    expectLoad("end wins", Slot1Resume, 4'd1);
    retire(8, 32'd330);
    idle(2);
    expectLoad("sole slot1", 32'd330, 4'd1);

    // Last process ends: back to IDLE with no reload.
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
    idle(2);
    expectIdle("end last");

    // Illegal ids are ignored.
    create(4'd0, 32'd123);
    create(4'd11, 32'd456);
    idle(2);
    expectIdle("bad ids");

    // Slot 5 alone, then slot 10 joins and the order wraps 10 -> 5.
    create(4'd5, 32'd500);
    idle(3);
    expectLoad("slot5 start", 32'd500, 4'd5);
    retire(8, 32'd555);
    idle(2);
    expectLoad("sole slot5", 32'd555, 4'd5);
    create(4'd10, 32'd1000);
    retire(8, 32'd560);
    idle(2);
    expectLoad("slot10", 32'd1000, 4'd10);
    retire(8, 32'd1010);
    idle(2);
    expectLoad("wrap", 32'd560, 4'd5);

    // proc_end on slot 5 with a create of slot 5 in the same cycle (refused).
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 4'd5, 32'd999);
    idle(2);
    expectLoad("self create", 32'd1010, 4'd10);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
    idle(4);
    expectIdle("end slot10");

    // A create during SELECT does not affect that selection.
    create(4'd4, 32'd400);
    idle(2);
    create(4'd1, 32'd111);
    expectLoad("late create", 32'd400, 4'd4);

    // Reset while in SELECT aborts the switch and wipes the table.
    retire(8, 32'd444);
    idle(1);
    checkOutput("pre-reset busy", 32'(bus.busy), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    idle(4);
    expectIdle("post reset");
    checkOutput("post reset next_pc", bus.next_pc, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
